// File: rtl/icc_branch_unit.sv
// SPARC integer condition-code register with ALU carry feedback and Bicc resolution.
// A Bicc in the same cycle as its cc-setting op sees the new flags; the result is registered.
module icc_branch_unit #(
  parameter logic [3:0] RESET_ICC = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_valid,
  input  logic       cc_we,
  input  logic [3:0] flags_in,
  input  logic       br_valid,
  input  logic [3:0] cond,
  input  logic       annul_bit,
  input  logic       stall,
  input  logic       flush,
  output logic [3:0] icc,
  output logic       alu_cin,
  output logic       br_done,
  output logic       br_taken,
  output logic       annul_next,
  output logic [1:0] cc_busy_cnt
);

  localparam int unsigned CC_W = 4;
  localparam logic [3:0]  COND_BA = 4'b1000;

  logic [CC_W-1:0] eff;
  logic            cc_commit;
  logic            br_commit;
  logic            taken;
  logic            annul;
  logic            n_f, z_f, v_f, c_f;

  assign cc_commit = alu_valid & cc_we & ~stall & ~flush;
  assign br_commit = br_valid & ~stall & ~flush;

  // Bypass freshly produced flags so a Bicc paired with its cc op sees them.
  assign eff = (alu_valid & cc_we) ? flags_in : icc;
  assign n_f = eff[3];
  assign z_f = eff[2];
  assign v_f = eff[1];
  assign c_f = eff[0];

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      4'b0000: taken = 1'b0;
      4'b1000: taken = 1'b1;
      4'b0001: taken = z_f;
      4'b1001: taken = ~z_f;
      4'b0010: taken = z_f | (n_f ^ v_f);
      4'b1010: taken = ~(z_f | (n_f ^ v_f));
      4'b0011: taken = n_f ^ v_f;
      4'b1011: taken = ~(n_f ^ v_f);
      4'b0100: taken = c_f | z_f;
      4'b1100: taken = ~(c_f | z_f);
      4'b0101: taken = c_f;
      4'b1101: taken = ~c_f;
      4'b0110: taken = n_f;
      4'b1110: taken = ~n_f;
      4'b0111: taken = v_f;
      4'b1111: taken = ~v_f;
      default: taken = 1'b0;
    endcase
  end

  // Delay slot is annulled when untaken, and also for BA,a.
  assign annul = annul_bit & (~taken | (cond == COND_BA));

  // Condition-code register and write-burst counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      icc         <= RESET_ICC;
      cc_busy_cnt <= 2'd0;
    end else begin
      if (cc_commit) begin
        icc <= flags_in;
      end
      if (!stall) begin
        if (cc_commit) begin
          cc_busy_cnt <= (cc_busy_cnt == 2'd3) ? 2'd3 : cc_busy_cnt + 2'd1;
        end else begin
          cc_busy_cnt <= 2'd0;
        end
      end
    end
  end

  // Branch result register; a stall stretches the pending result, flush clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      br_done    <= 1'b0;
      br_taken   <= 1'b0;
      annul_next <= 1'b0;
    end else if (br_commit) begin
      br_done    <= 1'b1;
      br_taken   <= taken;
      annul_next <= annul;
    end else if (flush || !stall) begin
      br_done    <= 1'b0;
      br_taken   <= 1'b0;
      annul_next <= 1'b0;
    end
  end

  assign alu_cin = icc[0];

endmodule

// File: tb/tb_icc_branch_unit.sv
// Scoreboard bench for icc_branch_unit: driver pushes reference-model expectations,
// monitor pops and compares one entry per clock.
module tb_icc_branch_unit;

  localparam logic [3:0] RST_ICC = 4'b1010;

  logic       clk;
  logic       reset;
  logic       alu_valid;
  logic       cc_we;
  logic [3:0] flags_in;
  logic       br_valid;
  logic [3:0] cond;
  logic       annul_bit;
  logic       stall;
  logic       flush;
  logic [3:0] icc;
  logic       alu_cin;
  logic       br_done;
  logic       br_taken;
  logic       annul_next;
  logic [1:0] cc_busy_cnt;

  icc_branch_unit #(.RESET_ICC(RST_ICC)) dut (
    .clk(clk), .reset(reset), .alu_valid(alu_valid), .cc_we(cc_we),
    .flags_in(flags_in), .br_valid(br_valid), .cond(cond), .annul_bit(annul_bit),
    .stall(stall), .flush(flush), .icc(icc), .alu_cin(alu_cin), .br_done(br_done),
    .br_taken(br_taken), .annul_next(annul_next), .cc_busy_cnt(cc_busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] icc;
    logic       done;
    logic       taken;
    logic       annul;
    logic [1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state
  logic [3:0] m_icc;
  logic       m_done, m_taken, m_annul;
  int         m_cnt;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got=%b want=%b", name, $time, got, want);
    end
  endtask

  // Bicc rule from the architecture table: low three bits pick a test, bit 3 negates it.
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy, base;
    n = f[3]; z = f[2]; v = f[1]; cy = f[0];
    case (c[2:0])
      3'd0: base = 1'b0;
      3'd1: base = z;
      3'd2: base = z || (n != v);
      3'd3: base = (n != v);
      3'd4: base = cy || z;
      3'd5: base = cy;
      3'd6: base = n;
      default: base = v;
    endcase
    return c[3] ? !base : base;
  endfunction

  task automatic cyc(input logic r, input logic av, input logic we, input logic [3:0] f,
                     input logic bv, input logic [3:0] c, input logic ab,
                     input logic st, input logic fl);
    exp_t e;
    logic [3:0] eff;
    logic t;
    @(negedge clk);
    reset = r; alu_valid = av; cc_we = we; flags_in = f;
    br_valid = bv; cond = c; annul_bit = ab; stall = st; flush = fl;
    if (r) begin
      m_icc = RST_ICC; m_cnt = 0; m_done = 0; m_taken = 0; m_annul = 0;
    end else begin
      eff = (av && we) ? f : m_icc;
      t = cond_holds(c, eff);
      if (av && we && !st && !fl) begin
        m_icc = f;
        if (m_cnt < 3) m_cnt = m_cnt + 1;
      end else if (!st) begin
        m_cnt = 0;
      end
      if (fl) begin
        m_done = 0; m_taken = 0; m_annul = 0;
      end else if (!st) begin
        if (bv) begin
          m_done = 1; m_taken = t; m_annul = ab && (!t || c == 4'b1000);
        end else begin
          m_done = 0; m_taken = 0; m_annul = 0;
        end
      end
    end
    e.icc = m_icc; e.done = m_done; e.taken = m_taken; e.annul = m_annul;
    e.cnt = 2'(m_cnt);
    sb.push_back(e);
  endtask

  // Monitor: the DUT presents a registered state every cycle; compare just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("icc", icc, e.icc);
        check("alu_cin", {3'b0, alu_cin}, {3'b0, e.icc[0]});
        check("br_done", {3'b0, br_done}, {3'b0, e.done});
        check("br_taken", {3'b0, br_taken}, {3'b0, e.taken});
        check("annul_next", {3'b0, annul_next}, {3'b0, e.annul});
        check("cc_busy_cnt", {2'b0, cc_busy_cnt}, {2'b0, e.cnt});
      end
    end
  end

  initial begin
    logic [3:0] seq [4];
    seq[0] = 4'b0001; seq[1] = 4'b0011; seq[2] = 4'b0000; seq[3] = 4'b1001;
    reset = 1; alu_valid = 0; cc_we = 0; flags_in = 0; br_valid = 0;
    cond = 0; annul_bit = 0; stall = 0; flush = 0;

    cyc(1, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0);
    cyc(1, 1, 1, 4'hF, 1, 4'h8, 1, 1, 1);        // reset beats stall/flush
    cyc(0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0);
    // BE paired with a Z-setting op sees the bypassed flags
    cyc(0, 1, 1, 4'b0100, 1, 4'b0001, 0, 0, 0);
    cyc(0, 1, 1, 4'b1000, 0, 4'h0, 0, 0, 0);
    cyc(0, 0, 0, 4'h0, 1, 4'b0011, 1, 0, 0);     // BL,a taken
    cyc(0, 0, 0, 4'h0, 1, 4'b1011, 1, 0, 0);     // BGE,a untaken
    cyc(0, 0, 0, 4'h0, 1, 4'b1000, 1, 0, 0);     // BA,a
    cyc(0, 0, 0, 4'h0, 1, 4'b0000, 1, 0, 0);     // BN,a
    // Branch, then stall with an ignored cc write, then flush while stalled
    cyc(0, 0, 0, 4'h0, 1, 4'b0110, 0, 0, 0);
    cyc(0, 0, 0, 4'h0, 1, 4'b0001, 1, 1, 0);
    cyc(0, 1, 1, 4'b0111, 0, 4'h0, 0, 1, 0);
    cyc(0, 0, 0, 4'h0, 0, 4'h0, 0, 1, 0);
    cyc(0, 0, 0, 4'h0, 1, 4'b1000, 0, 1, 1);
    cyc(0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0);
    // Back-to-back cc writes saturate the counter; idle clears it
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, seq[i], 0, 4'h0, 0, 0, 0);
    cyc(0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0);
    cyc(0, 1, 1, 4'b0001, 0, 4'h0, 0, 0, 0);
    cyc(0, 1, 1, 4'b0011, 0, 4'h0, 0, 0, 1);
    cyc(0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom), 4'($urandom),
          1'($urandom), 4'($urandom), 1'($urandom),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
    end
    cyc(0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("sb_drained", 4'(sb.size() > 0 ? 1 : 0), 4'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icc_branch_unit.md
Name: icc_branch_unit

Overview:
- Sits directly downstream of the 32-bit ALU (a, b, cin, opcode[3:0] -> y, flags[3:0]).
- Latches ALU flags into the SPARC integer condition-code register (icc) for cc-setting ops.
- Feeds the carry bit back to the ALU cin for ADDX/SUBX.
- Resolves Bicc conditions, with a same-cycle bypass of freshly produced flags, and produces a registered taken/annul result for fetch.

Parameters:
- RESET_ICC, 4'b0000, icc value loaded on reset.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- alu_valid  input  1  ALU result/flags valid this cycle
- cc_we  input  1  current ALU op sets icc (ADDcc, SUBcc, ANDcc, ...)
- flags_in  input  4  ALU flags: [3]=N, [2]=Z, [1]=V, [0]=C
- br_valid  input  1  Bicc instruction presented this cycle
- cond  input  4  Bicc cond field (SPARC encoding)
- annul_bit  input  1  Bicc 'a' bit
- stall  input  1  hold all state; no updates
- flush  input  1  discard this cycle's cc write and branch; clear the pending result
- icc  output  4  architectural condition codes {N,Z,V,C}
- alu_cin  output  1  equals icc[0]; combinational from the register
- br_done  output  1  registered pulse: branch result valid
- br_taken  output  1  registered; meaningful only when br_done=1
- annul_next  output  1  registered; delay slot must be annulled (qualified by br_done)
- cc_busy_cnt  output  2  saturating count of consecutive cycles with an icc write (hazard/perf monitor)

Behaviour:
- Reset (sync, on clk edge with reset=1):
  - icc=RESET_ICC; br_done=0, br_taken=0, annul_next=0, cc_busy_cnt=0.
  - Reset has priority over stall and flush. Reset mid-branch drops the result.
- cc write:
  - Occurs when alu_valid & cc_we & !stall & !flush; icc<=flags_in on the next edge.
  - Otherwise icc holds.
- Effective flags for branch evaluation (combinational):
  - eff = flags_in if alu_valid & cc_we, else icc.
  - This bypass means a Bicc presented in the same cycle as its cc-setting op sees the new flags.
  - The bypass applies even under flush/stall, but those suppress the result anyway.
- Condition evaluation, with N,Z,V,C taken from eff:
  - 0000 never; 1000 always
  - 0001 Z; 1001 !Z
  - 0010 Z|(N^V); 1010 !(Z|(N^V))
  - 0011 N^V; 1011 !(N^V)
  - 0100 C|Z; 1100 !(C|Z)
  - 0101 C; 1101 !C
  - 0110 N; 1110 !N
  - 0111 V; 1111 !V
- Branch result register (1-cycle latency):
  - If br_valid & !stall & !flush: br_done<=1, br_taken<=taken, annul_next<=annul_bit & (!taken | cond==4'b1000).
  - This is the SPARC rule: annul if untaken; BA,a annuls even though taken. BN,a annuls.
  - If !stall and no valid branch (or flush): br_done<=0, br_taken<=0, annul_next<=0.
  - If stall & !flush: all three hold. A br_done=1 pulse stretches while stalled.
  - flush overrides stall: outputs clear.
- cc_busy_cnt:
  - Increments on each committed cc write, saturating at 3.
  - Clears on any non-stalled cycle without a committed cc write.
  - Holds on stall.
- alu_cin tracks icc[0] with zero added latency: an ADDX in the cycle after ADDcc sees the updated carry.

Test Plan:
- Reset with RESET_ICC=4'b1010 -> icc=1010, alu_cin=0, br_done=0, cc_busy_cnt=0 after one edge.
- alu_valid=1, cc_we=1, flags_in=0100 (Z), same cycle br_valid=1, cond=0001 (BE), annul_bit=0 -> next edge: icc=0100, br_done=1, br_taken=1, annul_next=0.
- icc=1000 (N, V=0), cond=0011 (BL), annul_bit=1, no cc write -> br_taken=1, annul_next=0; repeat with cond=1011 (BGE) -> br_taken=0, annul_next=1.
- cond=1000 (BA), annul_bit=1 -> br_taken=1, annul_next=1. cond=0000 (BN), annul_bit=1 -> br_taken=0, annul_next=1.
- Branch issued, then stall=1 for 3 cycles -> br_done stays 1 with unchanged br_taken. A cc write during the stall is ignored (icc unchanged). flush=1 while stalled -> br_done=0 next edge.
- Four consecutive committed cc writes with flags 0001,0011,0000,1001 -> icc follows each one cycle later, alu_cin=1,1,0,1, cc_busy_cnt=1,2,3,3. An idle cycle -> 0. flush on the 2nd write leaves icc=0001.
